sysid_check_master: RTL and testbench

SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

---
 rtl/sysid_check_pkg.sv | 22 ++
 rtl/sysid_check_stall_cnt.sv | 32 +++
 rtl/sysid_check_master.sv | 142 ++++++++++++++
 tb/tb_sysid_check_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg
//   Shared types and constants for the system-ID check master:
//   FSM state enum, fail_code encodings and Avalon word addresses.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_e;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_ID      = 2'b01;
  localparam logic [1:0] FAIL_TS      = 2'b10;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b11;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_check_stall_cnt.sv
// sysid_check_stall_cnt
//   Counts consecutive waitrequest-stall cycles of the current read and
//   flags the cycle in which the LIMIT-th stall cycle occurs.
//   Ports:
//     clock    in   system clock
//     reset_n  in   async active-low reset
//     stall    in   read outstanding and slave stalling this cycle
//     expired  out  this cycle is stall cycle number LIMIT
module sysid_check_stall_cnt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stall,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  // A read ends on its first non-stall cycle, so clearing whenever stall
  // is low restarts the count for every new read.
  always_comb begin
    cnt_d   = stall ? cnt_q + 16'd1 : 16'd0;
    expired = stall && (cnt_q == 16'(LIMIT - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= 16'd0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sysid_check_master.sv
// sysid_check_master
//   On a start pulse, reads the system ID (word 0) and build timestamp
//   (word 1) from an Avalon-MM slave and compares them with EXPECTED_ID /
//   EXPECTED_TS, reporting pass / fail_code with a one-cycle done pulse.
//   Optional feature macro: SYSID_CHECK_TIMEOUT_EN -- aborts a read after
//   TIMEOUT_CYCLES stall cycles with fail_code 11.
//   Ports:
//     clock, reset_n                  clock, async active-low reset
//     start                           request a check (IDLE only)
//     avm_address, avm_read           Avalon-MM read master outputs
//     avm_waitrequest, avm_readdata   Avalon-MM slave response
//     busy, done, pass, fail_code     status
//     id_value, ts_value              last captured words
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1626704057,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sysid_check_master: TIMEOUT_CYCLES out of range 2..65535");
  end

  state_e      state_q, state_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        pass_q, pass_d;
  logic [1:0]  fail_q, fail_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic        rd_active, timeout;

  assign rd_active = (state_q == RD_ID) || (state_q == RD_TS);

`ifdef SYSID_CHECK_TIMEOUT_EN
  sysid_check_stall_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .stall   (rd_active && avm_waitrequest),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Reset release is synchronised; start is only honoured once both
  // stages have filled with ones.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    id_d    = id_q;
    ts_d    = ts_q;
    case (state_q)
      IDLE: if (start && rst_sync_q[1]) begin
        state_d = RD_ID;
        pass_d  = 1'b0;
        fail_d  = FAIL_NONE;
        id_d    = 32'd0;
        ts_d    = 32'd0;
      end
      RD_ID: if (timeout) begin
        state_d = FIN;
        fail_d  = FAIL_TIMEOUT;
        pass_d  = 1'b0;
      end else if (!avm_waitrequest) begin
        id_d    = avm_readdata;
        state_d = RD_TS;
      end
      RD_TS: if (timeout) begin
        state_d = FIN;
        fail_d  = FAIL_TIMEOUT;
        pass_d  = 1'b0;
      end else if (!avm_waitrequest) begin
        ts_d    = avm_readdata;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = FIN;
        // ID mismatch outranks TS mismatch
        if (id_q != EXPECTED_ID) begin
          pass_d = 1'b0;
          fail_d = FAIL_ID;
        end else if (ts_q != EXPECTED_TS) begin
          pass_d = 1'b0;
          fail_d = FAIL_TS;
        end else begin
          pass_d = 1'b1;
          fail_d = FAIL_NONE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
      state_q    <= IDLE;
      pass_q     <= 1'b0;
      fail_q     <= FAIL_NONE;
      id_q       <= 32'd0;
      ts_q       <= 32'd0;
    end else begin
      rst_sync_q <= rst_sync_d;
      state_q    <= state_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      id_q       <= id_d;
      ts_q       <= ts_d;
    end
  end

  // Bus and status outputs decode straight from the state register so a
  // reset drops them without waiting for an edge.
  assign avm_read    = rd_active;
  assign avm_address = (state_q == RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy        = rd_active || (state_q == CHECK);
  assign done        = (state_q == FIN);
  assign pass        = pass_q;
  assign fail_code   = fail_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master
//   Directed bench for sysid_check_master with a behavioural Avalon slave
//   that inserts wait_cfg stall cycles per read.
module tb_sysid_check_master;

  localparam logic [31:0] TS_OK = 32'h60F5_88B9;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int errors = 0;

  // slave model
  int          wait_cfg = 0;
  int          stall_ctr = 0;
  logic [31:0] id_data = 32'd0;
  logic [31:0] ts_data = TS_OK;

  assign avm_waitrequest = avm_read && (stall_ctr < wait_cfg);
  assign avm_readdata    = avm_address ? ts_data : id_data;

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_ctr <= stall_ctr + 1;
    else                             stall_ctr <= 0;
  end

  always #5 clock = ~clock;

  sysid_check_master #(.TIMEOUT_CYCLES(8)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_code       (fail_code),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  // start high across exactly one rising edge; returns at the negedge
  // after that edge (cycle N+1 relative to the start cycle N)
  task automatic kick();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // lat enters as the current cycle offset from the start cycle
  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clock); lat++;
    end
  endtask

  task automatic run_seq(input logic [31:0] idd, input logic [31:0] tsd,
                         input int w, output int lat);
    id_data = idd; ts_data = tsd; wait_cfg = w;
    kick();
    lat = 1;
    wait_done(lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({avm_address, avm_read, busy, done, pass, fail_code} !== 7'd0 ||
        id_value !== 32'd0 || ts_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%b rd=%b busy=%b done=%b pass=%b fc=%b id=%h ts=%h, want all 0",
               avm_address, avm_read, busy, done, pass, fail_code, id_value, ts_value);
    end
    // start on the first edge after release must be ignored (sync stage)
    reset_n = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    checks++;
    if (busy !== 1'b0 || avm_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_start: busy=%b rd=%b, want 0 0", busy, avm_read);
    end
  endtask

  task automatic test_id_mismatch();
    int lat;
    run_seq(32'h0000_0001, TS_OK, 0, lat);
    checks++;
    if (lat !== 4 || pass !== 1'b0 || fail_code !== 2'b01 || id_value !== 32'h1 || ts_value !== TS_OK) begin
      errors++;
      $display("FAIL id_mismatch: lat=%0d pass=%b fc=%b id=%h ts=%h, want 4 0 01 00000001 %h",
               lat, pass, fail_code, id_value, ts_value, TS_OK);
    end
  endtask

  task automatic test_pass();
    int lat;
    id_data = 32'd0; ts_data = TS_OK; wait_cfg = 0;
    kick();
    checks++;
    if (busy !== 1'b1 || avm_read !== 1'b1 || avm_address !== 1'b0 ||
        id_value !== 32'd0 || fail_code !== 2'b00 || done !== 1'b0) begin
      errors++;
      $display("FAIL pass_first_cycle: busy=%b rd=%b addr=%b id=%h fc=%b done=%b, want 1 1 0 0 00 0",
               busy, avm_read, avm_address, id_value, fail_code, done);
    end
    @(negedge clock);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 1'b1) begin
      errors++;
      $display("FAIL pass_ts_read: rd=%b addr=%b, want 1 1", avm_read, avm_address);
    end
    @(negedge clock);
    checks++;
    if (avm_read !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pass_check_state: rd=%b busy=%b, want 0 1", avm_read, busy);
    end
    lat = 3;
    wait_done(lat);
    checks++;
    if (lat !== 4 || pass !== 1'b1 || fail_code !== 2'b00 || busy !== 1'b0 ||
        id_value !== 32'd0 || ts_value !== TS_OK) begin
      errors++;
      $display("FAIL pass_result: lat=%0d pass=%b fc=%b busy=%b id=%h ts=%h, want 4 1 00 0 0 %h",
               lat, pass, fail_code, busy, id_value, ts_value, TS_OK);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL pass_done_pulse: done=%b pass=%b, want 0 1 (pulse, held)", done, pass);
    end
  endtask

  task automatic test_ts_mismatch();
    int lat;
    run_seq(32'd0, 32'h60F5_88BA, 0, lat);
    checks++;
    if (lat !== 4 || pass !== 1'b0 || fail_code !== 2'b10 || ts_value !== 32'h60F5_88BA) begin
      errors++;
      $display("FAIL ts_mismatch: lat=%0d pass=%b fc=%b ts=%h, want 4 0 10 60f588ba",
               lat, pass, fail_code, ts_value);
    end
    run_seq(32'hDEAD_BEEF, 32'h0, 0, lat);
    checks++;
    if (pass !== 1'b0 || fail_code !== 2'b01 || id_value !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL both_mismatch_priority: pass=%b fc=%b id=%h, want 0 01 deadbeef",
               pass, fail_code, id_value);
    end
  endtask

  task automatic test_stall();
    int   lat, nstall;
    bit   stable_ok, prev_stall;
    logic prev_addr;
    id_data = 32'd0; ts_data = TS_OK; wait_cfg = 3;
    kick();
    lat = 1; nstall = 0; stable_ok = 1'b1; prev_stall = 1'b0; prev_addr = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (prev_stall && (avm_read !== 1'b1 || avm_address !== prev_addr)) stable_ok = 1'b0;
      prev_stall = avm_waitrequest;
      prev_addr  = avm_address;
      if (avm_waitrequest) nstall++;
      @(negedge clock); lat++;
    end
    checks++;
    if (lat !== 10 || pass !== 1'b1 || fail_code !== 2'b00) begin
      errors++;
      $display("FAIL stall_result: lat=%0d pass=%b fc=%b, want 10 1 00", lat, pass, fail_code);
    end
    checks++;
    if (!stable_ok || nstall !== 6) begin
      errors++;
      $display("FAIL stall_stable: stable=%0d stalls=%0d, want 1 6", stable_ok, nstall);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    bit extra;
    id_data = 32'd0; ts_data = TS_OK; wait_cfg = 0;
    kick();
    start = 1'b1;               // sampled while in RD_ID
    @(negedge clock); start = 1'b0;
    lat = 2;
    wait_done(lat);
    checks++;
    if (lat !== 4 || pass !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_ignored: lat=%0d pass=%b, want 4 1", lat, pass);
    end
    start = 1'b1;               // sampled in the done cycle
    @(negedge clock); start = 1'b0;
    extra = 1'b0;
    repeat (6) begin
      if (busy !== 1'b0 || avm_read !== 1'b0 || done !== 1'b0) extra = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL done_start_ignored: activity after done-cycle start, want none");
    end
  endtask

`ifdef SYSID_CHECK_TIMEOUT_EN
  task automatic test_timeout();
    int lat, nread, ndone;
    id_data = 32'd0; ts_data = TS_OK; wait_cfg = 1000;
    kick();
    lat = 1; nread = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (avm_read === 1'b1) nread++;
      @(negedge clock); lat++;
    end
    checks++;
    if (nread !== 8 || lat !== 9 || fail_code !== 2'b11 || pass !== 1'b0) begin
      errors++;
      $display("FAIL timeout: reads=%0d lat=%0d fc=%b pass=%b, want 8 9 11 0",
               nread, lat, fail_code, pass);
    end
    ndone = 0;
    repeat (5) begin
      @(negedge clock);
      if (done === 1'b1 || avm_read === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL timeout_done_once: extra done/read cycles=%0d, want 0", ndone);
    end
    wait_cfg = 0;
  endtask
`else
  task automatic test_long_stall();
    int lat;
    run_seq(32'd0, TS_OK, 20, lat);
    checks++;
    if (lat !== 44 || pass !== 1'b1 || fail_code !== 2'b00) begin
      errors++;
      $display("FAIL long_stall_no_timeout: lat=%0d pass=%b fc=%b, want 44 1 00",
               lat, pass, fail_code);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n, ndone;
    id_data = 32'd0; ts_data = TS_OK; wait_cfg = 5;
    kick();
    start = 1'b1;               // busy-time start
    @(negedge clock); start = 1'b0;
    n = 0;
    while (!(avm_address === 1'b1 && avm_waitrequest === 1'b1) && n < 50) begin
      @(negedge clock); n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL reset_mid_reach_ts: RD_TS stall not reached, want within 50 cycles");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_address, avm_read, busy, done, pass, fail_code} !== 7'd0 ||
        id_value !== 32'd0 || ts_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_async: addr=%b rd=%b busy=%b done=%b pass=%b fc=%b id=%h, want all 0",
               avm_address, avm_read, busy, done, pass, fail_code, id_value);
    end
    @(negedge clock); reset_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1 || avm_read === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: active cycles after release=%0d, want 0", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_id_mismatch();
    test_pass();
    test_ts_mismatch();
    test_stall();
    test_start_ignored();
`ifdef SYSID_CHECK_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
